// File: rtl/packer_pkg.sv
// Shared types for the 64-to-512 packer.
// PACKER_FLUSH_EN selects whether a per-line word count is stored.
package packer_pkg;

    localparam int LANE_W = 64;
    localparam int LANES  = 8;
    localparam int LINE_W = 512;

    typedef logic [LANE_W-1:0] word_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [3:0]        count_t;

    typedef struct packed {
        line_t  data;
        count_t count;
    } entry_t;

`ifdef PACKER_FLUSH_EN
    typedef entry_t fifo_item_t;
`else
    typedef line_t fifo_item_t;
`endif

endpackage

// File: rtl/line_fifo.sv
// Single-clock show-ahead queue of completed lines.
// Item type follows PACKER_FLUSH_EN (line only, or line plus count).
module line_fifo
    import packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  fifo_item_t             push_item,
    input  logic                   pop,
    output fifo_item_t             head_item,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    fifo_item_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = level_q == FULL_LVL;
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head reads as zero when nothing is queued.
    assign head_item = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_item;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/packer_64_to_512.sv
// Gathers eight 64-bit words into a 512-bit line and queues lines.
// PACKER_FLUSH_EN enables closing a partial line via flush.
module packer_64_to_512
    import packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [LANE_W-1:0]      data_in,
    input  logic                   wr_enable,
    output logic                   full,
    input  logic                   flush,
    output logic [LINE_W-1:0]      data_out,
    output logic [3:0]             word_count,
    input  logic                   rd_enable,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [2:0]             lane
);

    logic [LANES-1:0][LANE_W-1:0] words_q;
    logic [LANES-1:0][LANE_W-1:0] words_d;
    logic [2:0]  lane_q;
    logic        wr_acc;
    logic        fl_acc;
    logic        push;
    line_t       push_line;
    fifo_item_t  push_item;
    fifo_item_t  head_item;

    assign wr_acc = wr_enable && !full;
    assign lane   = lane_q;

    always_comb begin
        words_d = words_q;
        if (wr_acc) begin
            words_d[lane_q] = data_in;
        end
    end

    // Open line is kept zeroed after each push, so partial lines are zero-filled.
    assign push_line = line_t'(words_d);

`ifdef PACKER_FLUSH_EN
    count_t push_count;

    assign fl_acc     = flush && !full;
    assign push_count = {1'b0, lane_q} + {3'b000, wr_acc};
    assign push       = (wr_acc && lane_q == 3'd7)
                      || (fl_acc && push_count != 4'd0);
    assign push_item  = '{data: push_line, count: push_count};
    assign data_out   = head_item.data;
    assign word_count = head_item.count;
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign fl_acc       = 1'b0;
    assign push         = wr_acc && lane_q == 3'd7;
    assign push_item    = push_line;
    assign data_out     = head_item;
    assign word_count   = empty ? 4'd0 : 4'd8;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            words_q <= '0;
        end else if (clr) begin
            lane_q  <= '0;
            words_q <= '0;
        end else if (push) begin
            lane_q  <= '0;
            words_q <= '0;
        end else if (wr_acc) begin
            lane_q  <= lane_q + 3'd1;
            words_q <= words_d;
        end
    end

    line_fifo #(
        .DEPTH(DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_item (push_item),
        .pop       (rd_enable),
        .head_item (head_item),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule

// File: tb/tb_packer_64_to_512.sv
// Directed bench for packer_64_to_512 with a queue-based reference model.
// Flush-specific literal checks apply when PACKER_FLUSH_EN is defined.
module tb_packer_64_to_512;
    import packer_pkg::*;

    localparam int DEPTH = 4;
`ifdef PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [63:0]  data_in = '0;
    logic         wr_enable = 1'b0;
    logic         flush = 1'b0;
    logic         rd_enable = 1'b0;
    logic         full;
    logic [511:0] data_out;
    logic [3:0]   word_count;
    logic         empty;
    logic [2:0]   level;
    logic [2:0]   lane;

    int checks = 0;
    int failures = 0;

    line_t mq[$];
    int    mc[$];
    word_t ow[8];
    int    ml;

    packer_64_to_512 #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .data_in    (data_in),
        .wr_enable  (wr_enable),
        .full       (full),
        .flush      (flush),
        .data_out   (data_out),
        .word_count (word_count),
        .rd_enable  (rd_enable),
        .empty      (empty),
        .level      (level),
        .lane       (lane)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        mc.delete();
        ml = 0;
        for (int i = 0; i < 8; i++) ow[i] = '0;
    endfunction

    // Spec-level model: queue of lines, list of open words.
    task automatic model_step();
        bit    m_full;
        bit    wa;
        bit    fa;
        line_t l;
        if (rst || clr) begin
            model_clear();
        end else begin
            m_full = mq.size() == DEPTH;
            wa = wr_enable && !m_full;
            fa = FLUSH_EN && flush && !m_full;
            if (rd_enable && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mc.pop_front());
            end
            if (wa) begin
                ow[ml] = data_in;
                ml++;
            end
            if (ml == 8 || (fa && ml > 0)) begin
                l = '0;
                for (int i = 0; i < ml; i++) l[i*64 +: 64] = ow[i];
                mq.push_back(l);
                mc.push_back(ml);
                for (int i = 0; i < 8; i++) ow[i] = '0;
                ml = 0;
            end
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        chk("empty", empty, n == 0);
        chk("full", full, n == DEPTH);
        chk("level", level, n);
        chk("lane", lane, ml % 8);
        chk("data_out", data_out, n > 0 ? mq[0] : '0);
        chk("word_count", word_count, n == 0 ? 0 : (FLUSH_EN ? mc[0] : 8));
    endtask

    always @(negedge clk) compare_all();

    task automatic step(bit wr, logic [63:0] d, bit fl, bit rd, bit cl);
        wr_enable = wr;
        data_in   = d;
        flush     = fl;
        rd_enable = rd;
        clr       = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        wr_enable = 1'b0;
        flush     = 1'b0;
        rd_enable = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    task automatic writes(int n, logic [63:0] base);
        for (int i = 0; i < n; i++) step(1, base + 64'(i), 0, 0, 0);
    endtask

    logic [63:0] w0;

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (3) idle();
        rst = 1'b0;
        idle();

        // Basic line: words 0..7
        writes(8, 64'h0);
        chk("lit_wc8", word_count, 4'd8);
        chk("lit_lo_word", data_out[63:0], 64'h0);
        chk("lit_hi_word", data_out[511:448], 64'h7);
        chk("lit_not_empty", empty, 1'b0);
        step(0, '0, 0, 1, 0);

        // Fill to DEPTH, drop extra write, refill after one pop
        writes(32, 64'h100);
        chk("lit_full", full, 1'b1);
        step(1, 64'hDEAD, 0, 0, 0);
        chk("lit_drop_level", level, 3'd4);
        chk("lit_drop_lane", lane, 3'd0);
        step(0, '0, 0, 1, 0);
        writes(8, 64'h200);
        repeat (3) step(0, '0, 0, 1, 0);
        chk("lit_line5_lo", data_out[63:0], 64'h200);
        chk("lit_line5_hi", data_out[511:448], 64'h207);
        step(0, '0, 0, 1, 0);
        chk("lit_drained", empty, 1'b1);

        // Flush cases
        step(0, '0, 0, 0, 1);
        writes(3, 64'h300);
        step(0, '0, 1, 0, 0);
`ifdef PACKER_FLUSH_EN
        chk("lit_fl_wc3", word_count, 4'd3);
        chk("lit_fl_zero", data_out[511:192], 320'h0);
        chk("lit_fl_lane", lane, 3'd0);
        chk("lit_fl_w2", data_out[191:128], 64'h302);
`endif
        step(0, '0, 0, 1, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        writes(2, 64'h400);
        step(1, 64'h402, 1, 0, 0);
`ifdef PACKER_FLUSH_EN
        chk("lit_wrfl_wc3", word_count, 4'd3);
`endif
        step(0, '0, 0, 0, 1);
        writes(7, 64'h500);
        step(1, 64'h507, 1, 0, 0);
        chk("lit_wrfl7_level", level, 3'd1);
        chk("lit_wrfl7_wc8", word_count, 4'd8);
        idle();

        // Pop with simultaneous completing write
        step(0, '0, 0, 0, 1);
        writes(8, 64'h600);
        writes(7, 64'h700);
        step(1, 64'h707, 0, 1, 0);
        chk("lit_popwr_level", level, 3'd1);
        chk("lit_popwr_data", data_out[63:0], 64'h700);

        // Async reset mid-line
        writes(5, 64'h800);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        compare_all();
        idle();
        rst = 1'b0;
        writes(8, 64'h900);
        w0 = data_out[63:0];
        chk("lit_rst_fresh", w0, 64'h900);
        chk("lit_rst_level", level, 3'd1);

        // Synchronous clear mid-line, with a write in the same cycle
        writes(5, 64'hA00);
        step(1, 64'hA05, 0, 1, 1);
        chk("lit_clr_empty", empty, 1'b1);
        chk("lit_clr_lane", lane, 3'd0);
        writes(8, 64'hB00);
        chk("lit_clr_fresh", data_out[63:0], 64'hB00);
        chk("lit_clr_hi", data_out[511:448], 64'hB07);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
